// File: rtl/spi_flash_read_sequencer.sv
// Autonomous SPI flash read sequencer: programs the SPI master core for a
// multi-word read, launches it, streams received words to a consumer with
// valid/ready handshaking and aborts the core if a word never arrives.
module spi_flash_read_sequencer #(
    parameter logic [7:0]  CLK_DIV      = 8'd4,
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter logic [15:0] DUMMY_CYCLES = 16'd0,
    parameter int          TIMEOUT      = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [23:0] rd_addr,
    input  logic [7:0]  rd_words,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [7:0]  spi_clk_div,
    output logic        spi_clk_div_valid,
    input  logic [31:0] spi_status,
    output logic [31:0] spi_cmd,
    output logic [5:0]  spi_cmd_len,
    output logic [31:0] spi_addr,
    output logic [5:0]  spi_addr_len,
    output logic [15:0] spi_data_len,
    output logic [15:0] spi_dummy_rd,
    output logic [3:0]  spi_csreg,
    output logic        spi_rd,
    output logic        spi_swrst,
    input  logic [31:0] spi_data_rx,
    input  logic        spi_data_rx_valid,
    output logic        spi_data_rx_ready
);

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int             TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT_IDLE,
        S_LAUNCH,
        S_RECV,
        S_ABORT,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [23:0]     r_addr;
    logic [7:0]      r_words;
    logic [7:0]      r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_error;
    logic            w_in_recv;
    logic            w_xfer;
    logic            w_stall;
    logic            w_accept;
    logic [30:0]     w_unused_status;

    assign w_unused_status = spi_status[31:1];

    // A word moves only in RECV; a stall is a cycle where the consumer waits
    // on the core, which is the only case that can time out.
    assign w_in_recv = (r_state == S_RECV);
    assign w_xfer    = w_in_recv & spi_data_rx_valid & rdata_ready;
    assign w_stall   = w_in_recv & ~spi_data_rx_valid & rdata_ready;
    assign w_accept  = (r_state == S_IDLE) & start;

    // Static configuration seen by the core; captured fields only move on an
    // accepted start, so they are stable for the whole transaction.
    assign spi_clk_div   = CLK_DIV;
    assign spi_cmd       = {READ_CMD, 24'h000000};
    assign spi_cmd_len   = 6'd8;
    assign spi_addr      = {r_addr, 8'h00};
    assign spi_addr_len  = 6'd24;
    assign spi_data_len  = {3'b000, r_words, 5'b00000};
    assign spi_dummy_rd  = DUMMY_CYCLES;
    assign spi_csreg     = 4'b0001;
    assign rdata         = spi_data_rx;
    assign error         = r_error;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_state_next      = r_state;
        busy              = 1'b1;
        done              = 1'b0;
        spi_clk_div_valid = 1'b0;
        spi_rd            = 1'b0;
        spi_swrst         = 1'b0;
        rdata_valid       = 1'b0;
        spi_data_rx_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (rd_words == 8'd0) ? S_FINISH : S_CFG;
                end
            end
            S_CFG: begin
                spi_clk_div_valid = 1'b1;
                w_state_next      = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (spi_status[0]) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                spi_rd       = 1'b1;
                w_state_next = S_RECV;
            end
            S_RECV: begin
                rdata_valid       = spi_data_rx_valid;
                spi_data_rx_ready = rdata_ready;
                if (w_xfer && (r_cnt == 8'd1)) begin
                    w_state_next = S_FINISH;
                end else if (w_stall && (r_tmo == TMO_LAST)) begin
                    w_state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                spi_swrst    = 1'b1;
                w_state_next = S_FINISH;
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, remaining-word count, stall timer and error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= 24'h000000;
            r_words <= 8'd0;
            r_cnt   <= 8'd0;
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_error <= 1'b0;
                if (rd_words != 8'd0) begin
                    r_addr  <= rd_addr;
                    r_words <= rd_words;
                    r_cnt   <= rd_words;
                end
            end
            if (r_state == S_ABORT) begin
                r_error <= 1'b1;
            end
            if (w_xfer) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if ((r_state == S_LAUNCH) || w_xfer) begin
                r_tmo <= '0;
            end else if (w_stall) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

endmodule

// File: doc/spi_flash_read_sequencer.md
Name: spi_flash_read_sequencer

Overview:
Autonomous controller that drives the SPI master core's configuration and stream ports to perform multi-word flash reads (boot/XIP prefetch) without CPU involvement. It accepts a request of start, byte address and word count, then programs the clock divider, command, address and length fields. It pulses the read strobe and streams received 32-bit words to a downstream consumer with valid/ready flow control. A per-word timeout detects a hung transfer, soft-resets the core and reports an error.

Parameters:
CLK_DIV, 8'd4, value driven on spi_clk_div and committed once per transaction.
READ_CMD, 8'h03, flash read opcode.
DUMMY_CYCLES, 16'd0, value driven on spi_dummy_rd (e.g. 8 when READ_CMD = 8'h0B).
TIMEOUT, 1024, max cycles waiting for an rx word while the consumer is ready; must be ≥ 2.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
rd_addr  in  24  flash byte address; captured on accepted start
rd_words  in  8  number of 32-bit words; captured on accepted start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at transaction end
error  out  1  qualifies done; 1 = timeout abort
rdata  out  32  received word (= spi_data_rx)
rdata_valid  out  1  spi_data_rx_valid gated by state==RECV
rdata_ready  in  1  consumer ready
spi_clk_div  out  8  divider value
spi_clk_div_valid  out  1  one-cycle commit pulse
spi_status  in  32  core status; bit0 = 1 means core idle
spi_cmd  out  32  {READ_CMD, 24'h0}
spi_cmd_len  out  6  constant 6'd8
spi_addr  out  32  {captured rd_addr, 8'h00}
spi_addr_len  out  6  constant 6'd24
spi_data_len  out  16  captured rd_words × 32 (i.e. {3'b0, rd_words, 5'b0})
spi_dummy_rd  out  16  DUMMY_CYCLES
spi_csreg  out  4  4'b0001 (chip select 0)
spi_rd  out  1  one-cycle read launch pulse
spi_swrst  out  1  one-cycle core soft-reset pulse
spi_data_rx  in  32  rx word from core FIFO
spi_data_rx_valid  in  1  rx word available
spi_data_rx_ready  out  1  rdata_ready gated by state==RECV

Behaviour:
- Reset:
  - State = IDLE; all pulses = 0; busy, done, error = 0.
  - Captured addr/words = 0; word counter and timeout counter = 0.
  - Constant config outputs hold their parameter/constant values.
- States: IDLE, CFG, WAIT_IDLE, LAUNCH, RECV, ABORT, FINISH.
- IDLE:
  - start with rd_words ≠ 0: capture addr/words, load counter = rd_words, go to CFG.
  - start with rd_words = 0: go to FINISH with error = 0; no SPI activity.
  - start outside IDLE is ignored (no queueing).
- CFG: assert spi_clk_div_valid for exactly 1 cycle, then go to WAIT_IDLE.
- WAIT_IDLE: stay until spi_status[0] = 1, then go to LAUNCH. No timeout applies here.
- LAUNCH: assert spi_rd for exactly 1 cycle; clear the timeout counter; go to RECV.
- RECV:
  - A word transfers when spi_data_rx_valid & rdata_ready; the counter decrements.
  - Transfer with counter = 1: go to FINISH, error = 0.
  - Timeout counter increments each cycle rdata_ready = 1 and spi_data_rx_valid = 0. It clears on a transfer and holds while rdata_ready = 0, so consumer backpressure never times out.
  - Counter reaching TIMEOUT−1 with no transfer that cycle: go to ABORT.
- ABORT: assert spi_swrst for 1 cycle, set the error flag, go to FINISH.
- FINISH: done = 1 for 1 cycle with error valid in the same cycle; return to IDLE. error holds until the next accepted start.
- Config outputs are stable from CFG through FINISH; captured values change only on an accepted start.
- rdata_valid and spi_data_rx_ready are 0 outside RECV; no rx word is consumed outside RECV.
- Latency from start to spi_rd, with the core already idle: start (IDLE) → CFG → WAIT_IDLE → LAUNCH, so spi_rd is asserted in the 3rd cycle after start.
- Asynchronous reset mid-transaction returns to IDLE immediately with no done pulse and no swrst pulse.

Test Plan:
- Basic read: rd_addr = 24'h001000, rd_words = 4, spi_status[0] = 1, rdata_ready = 1, rx words A,B,C,D → spi_cmd = 32'h03000000, spi_addr = 32'h00100000, spi_data_len = 128, one clk_div_valid pulse and one spi_rd pulse; rdata = A,B,C,D; done with error = 0 in the cycle after D.
- Busy core: spi_status[0] held 0 for 20 cycles after start → no spi_rd until bit0 rises; spi_rd follows 1 cycle after bit0 = 1.
- Backpressure: rdata_ready toggled 1/0 every cycle, rd_words = 3, rx_valid continuous, TIMEOUT = 4 → exactly 3 transfers, no abort, spi_data_rx_ready mirrors rdata_ready only in RECV.
- Timeout: TIMEOUT = 16, rd_words = 2, one word then rx_valid stuck at 0 with ready = 1 → spi_swrst pulses once about 16 cycles after the first word; done = 1 with error = 1; busy drops.
- Zero length and ignored start: rd_words = 0 → done after 1 cycle, no spi_rd or clk_div_valid; a second start during RECV leaves captured addr/len unchanged.
- Reset mid-RECV: HRESETn low while 2 of 4 words remain → all outputs return to reset values, no done pulse; a subsequent start works normally.
